// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the lab_MS_SV4 ALU and its issue queue.
package lab_MS_SV4_pack;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_MAX,
        OP_MIN
    } opc_t;

    typedef logic signed [7:0] data_y;

    typedef struct packed {
        opc_t  opc;
        data_y op_a;
        data_y op_b;
    } INST_t;

    localparam int unsigned ISSUE_DEPTH_DEF = 4;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Instruction-in and result-out handshake channels of the issue queue.
interface alu_issue_queue_if;
    import lab_MS_SV4_pack::*;

    logic  in_valid;
    logic  in_ready;
    INST_t in_inst;
    logic  res_valid;
    logic  res_ready;
    data_y res_data;
    opc_t  res_opc;

    modport master (
        output in_valid, in_inst, res_ready,
        input  in_ready, res_valid, res_data, res_opc
    );

    modport slave (
        input  in_valid, in_inst, res_ready,
        output in_ready, res_valid, res_data, res_opc
    );

endinterface

// File: rtl/alu_issue_queue_sync_fifo.sv
// Circular-buffer FIFO with first-word-fall-through head; DEPTH must be a power of two.
module sync_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem[rd_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/lab_MS_SV4.sv
// Combinational 8-bit signed ALU; results wrap to the data_y width.
module lab_MS_SV4
    import lab_MS_SV4_pack::*;
(
    input  INST_t INST,
    output data_y ALU_out
);

    always_comb begin
        ALU_out = '0;
        unique case (INST.opc)
            OP_ADD: ALU_out = INST.op_a + INST.op_b;
            OP_SUB: ALU_out = INST.op_a - INST.op_b;
            OP_AND: ALU_out = INST.op_a & INST.op_b;
            OP_OR:  ALU_out = INST.op_a | INST.op_b;
            OP_XOR: ALU_out = INST.op_a ^ INST.op_b;
            OP_SHL: ALU_out = INST.op_a <<< 1;
            OP_MAX: ALU_out = (INST.op_a > INST.op_b) ? INST.op_a : INST.op_b;
            OP_MIN: ALU_out = (INST.op_a < INST.op_b) ? INST.op_a : INST.op_b;
        endcase
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Feeds the lab_MS_SV4 ALU: FIFO -> registered issue stage -> registered result stage.
module alu_issue_queue
    import lab_MS_SV4_pack::*;
#(
    parameter int unsigned DEPTH = ISSUE_DEPTH_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_queue_if.slave       bus,
    output INST_t                  INST,
    input  data_y                  ALU_out,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       issued_cnt
);

    localparam opc_t OPC_FIRST = OP_ADD;

    INST_t            fifo_head;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic             issue_adv, res_adv;

    INST_t            inst_q, inst_d;
    logic             iss_valid_q, iss_valid_d;
    logic             res_valid_q, res_valid_d;
    data_y            res_data_q, res_data_d;
    opc_t             res_opc_q, res_opc_d;
    logic [CNT_W-1:0] issued_q, issued_d;

    // in_ready depends only on FIFO occupancy, never on res_ready.
    assign bus.in_ready  = rst_n && !fifo_full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_opc   = res_opc_q;
    assign INST          = inst_q;
    assign issued_cnt    = issued_q;

    sync_fifo #(
        .T     (INST_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.in_inst),
        .head  (fifo_head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        res_adv     = !res_valid_q || bus.res_ready;
        issue_adv   = !iss_valid_q || res_adv;
        push        = bus.in_valid && bus.in_ready;
        pop         = issue_adv && !fifo_empty;

        inst_d      = inst_q;
        iss_valid_d = iss_valid_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_opc_d   = res_opc_q;
        issued_d    = issued_q;

        // An empty FIFO keeps INST stable so the ALU output does not toggle.
        if (issue_adv) begin
            iss_valid_d = !fifo_empty;
            if (!fifo_empty) inst_d = fifo_head;
        end
        if (res_adv) begin
            res_valid_d = iss_valid_q;
            res_data_d  = ALU_out;
            res_opc_d   = inst_q.opc;
        end
        if (res_valid_q && bus.res_ready) issued_d = issued_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_q      <= '{opc: OPC_FIRST, op_a: '0, op_b: '0};
            iss_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_opc_q   <= OPC_FIRST;
            issued_q    <= '0;
        end else begin
            inst_q      <= inst_d;
            iss_valid_q <= iss_valid_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_opc_q   <= res_opc_d;
            issued_q    <= issued_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue driving the real lab_MS_SV4 ALU, with an ordered result scoreboard.
module tb_alu_issue_queue;
    import lab_MS_SV4_pack::*;

    typedef struct {
        opc_t  opc;
        data_y a;
        data_y b;
        data_y exp;
    } vec_t;

    typedef struct {
        opc_t  opc;
        data_y data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    INST_t       inst;
    data_y       alu_out;
    logic [2:0]  count;
    logic [15:0] issued_cnt;

    always #5 clk = ~clk;

    alu_issue_queue_if bus ();

    alu_issue_queue #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .INST       (inst),
        .ALU_out    (alu_out),
        .count      (count),
        .issued_cnt (issued_cnt)
    );

    lab_MS_SV4 alu (
        .INST    (inst),
        .ALU_out (alu_out)
    );

    int   errors = 0;
    int   checks = 0;
    sb_t  sb[$];
    int   exp_issued = 0;
    int   res_seen = 0;
    int   cyc = 0;
    int   first_res_cyc = -1;
    int   last_res_cyc = -1;
    vec_t tbl[16];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic data_y model(input opc_t o, input data_y a, input data_y b);
        int ia = a;
        int ib = b;
        int r  = 0;
        case (o)
            OP_ADD: r = ia + ib;
            OP_SUB: r = ia - ib;
            OP_AND: r = ia & ib;
            OP_OR:  r = ia | ib;
            OP_XOR: r = ia ^ ib;
            OP_SHL: r = ia * 2;
            OP_MAX: r = (ia > ib) ? ia : ib;
            OP_MIN: r = (ia < ib) ? ia : ib;
            default: r = 0;
        endcase
        return data_y'(r);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Decisions for the upcoming edge are taken at the falling edge, where inputs are stable.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            sb.delete();
            exp_issued = 0;
        end else if (bus.res_valid && bus.res_ready) begin
            res_seen++;
            exp_issued++;
            if (first_res_cyc < 0) first_res_cyc = cyc;
            last_res_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: actual=%0d required=no result", bus.res_data);
            end else begin
                e = sb.pop_front();
                chk("res_data", bus.res_data, e.data);
                chk("res_opc", bus.res_opc, e.opc);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_one(input opc_t o, input data_y a, input data_y b, input data_y e);
        bus.in_valid = 1'b1;
        bus.in_inst  = '{opc: o, op_a: a, op_b: b};
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{opc: o, data: e});
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL push_timeout: actual=in_ready low required=accept within 64 cycles");
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int t = 0; t < 100 && sb.size() != 0; t++) cycles(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", sb.size());
        end
        cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int acc;
        data_y a;
        data_y b;

        tbl = '{
            '{OP_ADD, 127, 127, -2},   '{OP_SUB, 127, 127, 0},
            '{OP_AND, 127, 127, 127},  '{OP_OR,  127, 127, 127},
            '{OP_XOR, 127, 127, 0},    '{OP_SHL, 127, 127, -2},
            '{OP_MAX, 127, 127, 127},  '{OP_MIN, 127, 127, 127},
            '{OP_ADD, -128, -128, 0},  '{OP_SUB, -128, -128, 0},
            '{OP_AND, -128, -128, -128}, '{OP_OR, -128, -128, -128},
            '{OP_XOR, -128, -128, 0},  '{OP_SHL, -128, -128, 0},
            '{OP_MAX, -128, -128, -128}, '{OP_MIN, -128, -128, -128}
        };

        // Reset hold with an offered instruction.
        bus.in_valid  = 1'b1;
        bus.in_inst   = '{opc: OP_SUB, op_a: 8'sd3, op_b: 8'sd4};
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        cycles(3);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_inst_op_a", inst.op_a, 0);
        chk("rst_res_opc", bus.res_opc, OP_ADD);
        chk("rst_issued", issued_cnt, 0);

        // Single op and its two-edge latency.
        bus.in_valid  = 1'b0;
        rst_n         = 1'b1;
        bus.res_ready = 1'b1;
        cycles(1);
        push_one(OP_ADD, 8'sd10, -8'sd5, model(OP_ADD, 8'sd10, -8'sd5));
        bus.in_valid = 1'b0;
        chk("single_count_n", count, 1);
        chk("single_valid_n", bus.res_valid, 0);
        cycles(1);
        chk("single_count_n1", count, 0);
        chk("single_inst_a_n1", inst.op_a, 10);
        chk("single_valid_n1", bus.res_valid, 0);
        cycles(1);
        chk("single_valid_n2", bus.res_valid, 1);
        chk("single_data_n2", bus.res_data, 5);
        chk("single_opc_n2", bus.res_opc, OP_ADD);
        cycles(1);
        chk("single_issued", issued_cnt, 1);
        chk("single_valid_n3", bus.res_valid, 0);

        // Streaming all opcodes at the operand extremes, back to back.
        s0 = res_seen;
        first_res_cyc = -1;
        for (int i = 0; i < 16; i++) push_one(tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].exp);
        drain();
        chk("stream_count", res_seen - s0, 16);
        chk("stream_span", last_res_cyc - first_res_cyc, 15);
        chk("stream_issued", issued_cnt, exp_issued);

        // Full FIFO under backpressure, then drain.
        bus.res_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            a = data_y'(k * 9 - 20);
            b = data_y'(k + 1);
            bus.in_valid = 1'b1;
            bus.in_inst  = '{opc: opc_t'(k), op_a: a, op_b: b};
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{opc: opc_t'(k), data: model(opc_t'(k), a, b)});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("full_accepted", acc, 6);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_count", count, 4);
        chk("full_res_valid", bus.res_valid, 1);
        s0 = res_seen;
        bus.res_ready = 1'b1;
        drain();
        chk("full_drained", res_seen - s0, 6);
        chk("full_issued", issued_cnt, exp_issued);

        // Simultaneous push and pop holding count at 2.
        bus.res_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_one(OP_MAX, data_y'(k), 8'sd2, model(OP_MAX, data_y'(k), 8'sd2));
        chk("pp_count_setup", count, 2);
        bus.res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a = data_y'(-k * 30);
            push_one(OP_MIN, a, -8'sd50, model(OP_MIN, a, -8'sd50));
            chk("pp_count_hold", count, 2);
        end
        drain();

        // Reset in the middle of a backpressured stream.
        bus.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_one(OP_OR, data_y'(k), 8'sd16, model(OP_OR, data_y'(k), 8'sd16));
        chk("mid_count_pre", count, 3);
        chk("mid_valid_pre", bus.res_valid, 1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        cycles(1);
        chk("mid_count_rst", count, 0);
        chk("mid_valid_rst", bus.res_valid, 0);
        chk("mid_issued_rst", issued_cnt, 0);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        cycles(1);
        s0 = res_seen;
        push_one(OP_XOR, 8'sd85, 8'sd15, model(OP_XOR, 8'sd85, 8'sd15));
        drain();
        cycles(3);
        chk("mid_new_results", res_seen - s0, 1);
        chk("mid_issued_post", issued_cnt, exp_issued);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
